// File: rtl/block_stream_gen.sv
// block_stream_gen -- token-to-ASCII serializer feeding the block-nesting checker.
//
// Tokens (BEGIN, END, single-char WORD, SPACE) arrive over a valid/ready
// handshake. Each token is expanded into ASCII bytes followed by one trailing
// space, and one byte is emitted per clock on a registered output. The nesting
// depth and the balance verdict are tracked so that they match what the
// downstream checker is expected to conclude.
//
// Parameters:
//   DEPTH_W  width of the nesting-depth counter (saturates at all-ones)
//   UPPER    1 = keywords emitted as "BEGIN"/"END", 0 = "begin"/"end"
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   tok_valid  token offered
//   tok_ready  token can be accepted this cycle
//   tok_type   00 BEGIN, 01 END, 10 WORD, 11 SPACE
//   tok_char   character for WORD tokens
//   out        ASCII byte to the checker (registered; 8'h20 when idle)
//   out_valid  out carries a token byte
//   depth      current nesting depth
//   balanced   depth == 0 and no underflow seen
//   underflow  sticky: END emitted at depth 0
//   overflow   sticky: BEGIN at saturated depth
//   drop       one-cycle pulse when an unmatched END is swallowed
//
// Optional feature macro: BLOCK_GUARD_EN
//   defined   -> an END that would underflow is swallowed silently (drop pulses)
//   undefined -> that END is emitted and sets underflow; drop is tied low
module block_stream_gen #(
  parameter int DEPTH_W = 16,
  parameter int UPPER   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tok_valid,
  output logic               tok_ready,
  input  logic [1:0]         tok_type,
  input  logic [7:0]         tok_char,
  output logic [7:0]         out,
  output logic               out_valid,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               underflow,
  output logic               overflow,
  output logic               drop
);

  localparam logic [1:0] T_BEGIN = 2'b00;
  localparam logic [1:0] T_END   = 2'b01;
  localparam logic [1:0] T_WORD  = 2'b10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  // Keyword letters are stored as uppercase codes; OR-ing in 0x20 lowers them.
  localparam logic [7:0] CASE_BIT = (UPPER != 0) ? 8'h00 : 8'h20;
  localparam logic [7:0] SP       = 8'h20;

  function automatic logic [7:0] kw(input logic [7:0] uc);
    return uc | CASE_BIT;
  endfunction

  // Byte number i of a token, trailing space included.
  function automatic logic [7:0] tok_byte(input logic [1:0] t, input logic [7:0] c,
                                          input logic [2:0] i);
    logic [7:0] b;
    b = SP;
    case (t)
      T_BEGIN: begin
        case (i)
          3'd0:    b = kw(8'h42);
          3'd1:    b = kw(8'h45);
          3'd2:    b = kw(8'h47);
          3'd3:    b = kw(8'h49);
          3'd4:    b = kw(8'h4E);
          default: b = SP;
        endcase
      end
      T_END: begin
        case (i)
          3'd0:    b = kw(8'h45);
          3'd1:    b = kw(8'h4E);
          3'd2:    b = kw(8'h44);
          default: b = SP;
        endcase
      end
      T_WORD:  b = (i == 3'd0) ? c : SP;
      default: b = SP;
    endcase
    return b;
  endfunction

  // Index of the trailing space for each token type.
  function automatic logic [2:0] tok_last(input logic [1:0] t);
    logic [2:0] l;
    case (t)
      T_BEGIN: l = 3'd5;
      T_END:   l = 3'd3;
      T_WORD:  l = 3'd1;
      default: l = 3'd0;
    endcase
    return l;
  endfunction

  logic [0:0]         state;
  logic [2:0]         idx;
  logic [1:0]         cur_type;
  logic [7:0]         cur_char;
  logic               at_last;
  logic               accept;
  logic               start;
  logic [DEPTH_W-1:0] depth_nxt;
  logic               uf_nxt;
  logic               of_nxt;

  // idx always names the byte currently shown on out.
  assign at_last   = (state == ST_EMIT) && (idx == tok_last(cur_type));
  assign tok_ready = (state == ST_IDLE) || at_last;
  assign accept    = tok_valid && tok_ready;
  assign balanced  = (depth == '0) && !underflow;

  // Depth commits on the edge that retires a token's trailing space.
  always_comb begin
    depth_nxt = depth;
    uf_nxt    = underflow;
    of_nxt    = overflow;
    if (at_last) begin
      case (cur_type)
        T_BEGIN: begin
          if (&depth) of_nxt = 1'b1;
          else        depth_nxt = depth + DEPTH_W'(1);
        end
        T_END: begin
          if (depth == '0) uf_nxt = 1'b1;
          else             depth_nxt = depth - DEPTH_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef BLOCK_GUARD_EN
  logic swallow;
  logic drop_q;

  // depth_nxt already includes any BEGIN retiring on this edge, so a BEGIN
  // still in flight keeps the following END from being swallowed.
  assign swallow = accept && (tok_type == T_END) && (depth_nxt == '0);
  assign start   = accept && !swallow;
  assign drop    = drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_q <= 1'b0;
    else        drop_q <= swallow;
  end
`else
  assign start = accept;
  assign drop  = 1'b0;
`endif

  // Output byte register stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      idx       <= 3'd0;
      cur_type  <= 2'b00;
      cur_char  <= 8'h00;
      out       <= SP;
      out_valid <= 1'b0;
      depth     <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      depth     <= depth_nxt;
      underflow <= uf_nxt;
      overflow  <= of_nxt;
      if (start) begin
        state     <= ST_EMIT;
        idx       <= 3'd0;
        cur_type  <= tok_type;
        cur_char  <= tok_char;
        out       <= tok_byte(tok_type, tok_char, 3'd0);
        out_valid <= 1'b1;
      end else if ((state == ST_EMIT) && !at_last) begin
        idx <= idx + 3'd1;
        out <= tok_byte(cur_type, cur_char, idx + 3'd1);
      end else begin
        state     <= ST_IDLE;
        idx       <= 3'd0;
        out       <= SP;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/block_stream_gen.md
Name: block_stream_gen

Overview:
Token-to-ASCII serializer that produces the character stream consumed by the block-nesting checker. It accepts abstract tokens (BEGIN, END, single-char WORD, SPACE) over a valid/ready handshake and emits one ASCII byte per clock, with each token followed by one trailing space. It tracks nesting depth and exposes the balance verdict the downstream checker is expected to reach. Used as a stimulus source and loopback partner for the checker.

Parameters:
DEPTH_W, 16, width of the nesting-depth counter.
UPPER, 0, 1 = emit keywords in uppercase ("BEGIN", "END"); 0 = lowercase.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
tok_valid  input  1  token offered.
tok_ready  output  1  generator can accept a token this cycle.
tok_type  input  2  00 BEGIN, 01 END, 10 WORD, 11 SPACE.
tok_char  input  8  ASCII byte for WORD; ignored otherwise.
out  output  8  ASCII byte to the checker (registered).
out_valid  output  1  out carries a token byte.
depth  output  DEPTH_W  current nesting depth.
balanced  output  1  (depth == 0) && !underflow.
underflow  output  1  sticky; END emitted at depth 0.
overflow  output  1  sticky; BEGIN at saturated depth.
drop  output  1  one-cycle pulse; END discarded (BLOCK_GUARD_EN only).

Behaviour:
- Reset (reset = 0): state IDLE, out = 8'h20, out_valid = 0, depth = 0, underflow = 0, overflow = 0, drop = 0, tok_ready = 1, balanced = 1.
- States:
  - IDLE: out = 8'h20, out_valid = 0.
  - EMIT: idx is a 3-bit character index; out_valid = 1.
- Handshake: accept when tok_valid && tok_ready at a rising edge. Data is latched at that edge. The first byte appears on out in the next cycle (latency 1).
- tok_ready = 1 in IDLE, and in EMIT during the last byte of the current token. This allows back-to-back tokens with no idle gap.
- Byte sequences (each ends with 8'h20):
  - BEGIN: b,e,g,i,n,' ' (6 cycles).
  - END: e,n,d,' ' (4 cycles).
  - WORD: tok_char,' ' (2 cycles).
  - SPACE: ' ' (1 cycle).
  - When UPPER = 1, keyword letters use codes 0x42, 0x45, 0x47, 0x49, 0x4E, 0x44.
- Exit from EMIT: after the last byte, go to IDLE if no token is accepted, otherwise start the next token at idx = 0.
- WORD with tok_char = 8'h20: emitted verbatim. The resulting double space is legal for the checker.
- depth / underflow / overflow update at the clock edge that ends the token's trailing-space cycle. This is the same byte on which the checker commits its decision.
  - BEGIN: depth + 1. If depth is already all-ones, hold depth and set overflow.
  - END at depth > 0: depth - 1.
  - END at depth 0: depth stays 0 and underflow is set; it stays set until reset.
- balanced is combinational from depth and underflow.
- Reset asserted mid-token: output returns to 8'h20 / out_valid = 0 at once. The partial word is abandoned and the checker sees a truncated word followed by spaces.
- tok_type / tok_char changes while the token is not accepted are ignored.

Optional Feature:
BLOCK_GUARD_EN
- Defined: an END accepted while depth == 0, and with no BEGIN currently in flight, is consumed without emitting any bytes. drop pulses high for 1 cycle on the accept edge, the FSM stays in or returns to IDLE, and underflow never sets.
- Undefined: that END is emitted normally and sets underflow. drop is tied to 0.

Test Plan:
- Reset release, accept BEGIN -> out sequence 62,65,67,69,6E,20 on cycles 1..6; then depth = 1, balanced = 0.
- BEGIN then END back-to-back (tok_valid held) -> 10 consecutive out_valid cycles "begin end "; depth 0, balanced = 1; tok_ready high on cycles 6 and 10.
- UPPER = 1, WORD 'x' then END at depth 0 -> "x END " on out. Guard undefined: underflow = 1, balanced = 0, and both stay set after a later BEGIN + END.
- BLOCK_GUARD_EN defined, END at depth 0 -> no out_valid, drop = 1 for 1 cycle, underflow = 0, balanced = 1.
- DEPTH_W = 2, four BEGINs -> depth stops at 3, overflow = 1 after the 4th trailing space.
- Reset asserted on byte 3 of BEGIN -> out = 20 and out_valid = 0 immediately; depth = 0, tok_ready = 1 after release.
